// File: rtl/i2c_master_wr_if.sv
// Command/status handshake between the on-chip controller (master) and the I2C write
// engine (slave).
interface i2c_master_wr_if;
    logic       cmd_start;
    logic       cmd_write;
    logic       cmd_stop;
    logic [7:0] tx_data;
    logic       ready;
    logic       busy;
    logic       tx_done;
    logic       ack_err;

    modport master (
        output cmd_start, cmd_write, cmd_stop, tx_data,
        input  ready, busy, tx_done, ack_err
    );
    modport slave (
        input  cmd_start, cmd_write, cmd_stop, tx_data,
        output ready, busy, tx_done, ack_err
    );
endinterface

// File: rtl/i2c_master_wr.sv
// Single-master I2C write engine: START, MSB-first bytes with ACK sampling, STOP.
// Each bus state is four quarter-periods of CLK_FREQ/(4*SCL_FREQ) clocks.
module i2c_master_wr #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCL_FREQ = 100_000
) (
    input  logic           clk,
    input  logic           reset,
    i2c_master_wr_if.slave bus,
    output logic           scl,
    inout  wire            sda
);
    localparam int unsigned Div  = CLK_FREQ / (4 * SCL_FREQ);
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StHold, StData, StAck, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            ack_q, ack_d;
    logic            ack_err_q, ack_err_d;
    logic            tx_done_q, tx_done_d;
    logic [1:0]      sda_sync_q;
    logic            tick, last_qtr, sda_low;

    assign tick     = (cnt_q == CntW'(Div - 1));
    assign last_qtr = tick && (qtr_q == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            qtr_q      <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            ack_q      <= 1'b0;
            ack_err_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            sda_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            ack_q      <= ack_d;
            ack_err_q  <= ack_err_d;
            tx_done_q  <= tx_done_d;
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        ack_d     = ack_q;
        ack_err_d = ack_err_q;
        tx_done_d = 1'b0;
        if (tick) begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            qtr_d = qtr_q;
        end
        case (state_q)
            StIdle:  if (bus.cmd_start) state_d = StStart;
            StStart: if (last_qtr) state_d = StHold;
            StHold: begin
                // A simultaneous write and stop keeps the write; the stop is dropped.
                if (bus.cmd_write) begin
                    shreg_d   = bus.tx_data;
                    bit_cnt_d = 3'd7;
                    state_d   = StData;
                end else if (bus.cmd_stop) begin
                    state_d = StStop;
                end
            end
            StData: begin
                if (last_qtr) begin
                    if (bit_cnt_q == 3'd0) state_d = StAck;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            StAck: begin
                if (tick && qtr_q == 2'd1) ack_d = sda_sync_q[1];
                if (last_qtr) begin
                    tx_done_d = 1'b1;
                    ack_err_d = ack_q;
                    state_d   = StHold;
                end
            end
            StStop:  if (last_qtr) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Quarter timing restarts on every state entry and is frozen while waiting.
        if (state_q == StIdle || state_q == StHold || state_d != state_q) begin
            cnt_d = '0;
            qtr_d = '0;
        end
    end

    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state_q)
            StIdle: begin
                scl     = 1'b1;
                sda_low = 1'b0;
            end
            StStart: begin
                scl     = (qtr_q < 2'd2);
                sda_low = 1'b1;
            end
            StHold: begin
                scl     = 1'b0;
                sda_low = 1'b1;
            end
            StData: begin
                scl     = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_low = ~shreg_q[bit_cnt_q];
            end
            StAck: begin
                scl     = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_low = 1'b0;
            end
            StStop: begin
                scl     = (qtr_q != 2'd0);
                sda_low = (qtr_q < 2'd2);
            end
            default: begin
                scl     = 1'b1;
                sda_low = 1'b0;
            end
        endcase
    end

    assign sda         = sda_low ? 1'b0 : 1'bz;
    assign bus.ready   = (state_q == StIdle) || (state_q == StHold);
    assign bus.busy    = (state_q != StIdle);
    assign bus.tx_done = tx_done_q;
    assign bus.ack_err = ack_err_q;
endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: transaction-level bus model checked every cycle, a reactive
// I2C slave on the open-drain line, and directed scenarios with literal expectations.
module tb_i2c_master_wr;
    localparam int Div = 250;
    localparam int MIdle = 0, MStart = 1, MHold = 2, MData = 3, MStop = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic scl;
    wire  sda;
    logic s_drive = 1'b0;
    logic ack_en  = 1'b1;

    i2c_master_wr_if bus_if ();

    i2c_master_wr #(.CLK_FREQ(100_000_000), .SCL_FREQ(100_000)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if),
        .scl  (scl),
        .sda  (sda)
    );

    always #5 clk = ~clk;
    pullup (sda);
    assign sda = s_drive ? 1'b0 : 1'bz;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Transaction-level model: segment kind plus cycles elapsed in it.
    int         m_kind = MIdle, m_cnt = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_acken = 1'b1, m_txdone = 1'b0, m_ackerr = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_kind   <= MIdle;
            m_cnt    <= 0;
            m_txdone <= 1'b0;
            m_ackerr <= 1'b0;
        end else begin
            m_txdone <= 1'b0;
            m_cnt    <= m_cnt + 1;
            case (m_kind)
                MIdle: if (bus_if.cmd_start) begin m_kind <= MStart; m_cnt <= 0; end
                MStart: if (m_cnt == 4*Div-1) begin m_kind <= MHold; m_cnt <= 0; end
                MHold: begin
                    if (bus_if.cmd_write) begin
                        m_kind <= MData; m_cnt <= 0;
                        m_byte <= bus_if.tx_data; m_acken <= ack_en;
                    end else if (bus_if.cmd_stop) begin
                        m_kind <= MStop; m_cnt <= 0;
                    end
                end
                MData: begin
                    if (m_cnt == 36*Div-1) begin
                        m_kind <= MHold; m_cnt <= 0;
                        m_txdone <= 1'b1; m_ackerr <= !m_acken;
                    end
                end
                MStop: if (m_cnt == 4*Div-1) begin m_kind <= MIdle; m_cnt <= 0; end
                default: ;
            endcase
        end
    end

    function automatic void model_bus(output logic e_scl, output logic e_sda, output logic care);
        int q, ph, bn;
        q = m_cnt / Div;
        care = 1'b1;
        e_scl = 1'b1;
        e_sda = 1'b1;
        case (m_kind)
            MStart: begin e_scl = (q < 2); e_sda = 1'b0; end
            MHold:  begin e_scl = 1'b0; e_sda = 1'b0; end
            MData: begin
                ph = q % 4;
                bn = q / 4;
                e_scl = (ph == 1 || ph == 2);
                care  = e_scl;  // data is only defined while SCL is high
                e_sda = (bn < 8) ? m_byte[7-bn] : !m_acken;
            end
            MStop:  begin e_scl = (q != 0); e_sda = (q >= 2); end
            default: ;
        endcase
    endfunction

    initial begin
        logic e_scl, e_sda, care;
        forever begin
            @(negedge clk);
            model_bus(e_scl, e_sda, care);
            chk("scl", scl, e_scl);
            if (care) chk("sda", sda, e_sda);
            chk("ready", bus_if.ready, (m_kind == MIdle || m_kind == MHold));
            chk("busy", bus_if.busy, (m_kind != MIdle));
            chk("tx_done", bus_if.tx_done, m_txdone);
            chk("ack_err", bus_if.ack_err, m_ackerr);
        end
    end

    // Bus-reactive slave: shifts bits on SCL rise, ACKs after the 8th fall.
    int         s_bits = 0;
    logic [7:0] s_rx = 8'h00;
    logic       s_pscl = 1'b1, s_psda = 1'b1;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        s_pscl <= scl;
        s_psda <= sda;
        if (s_pscl && scl && s_psda && !sda) begin
            s_bits  <= 0;
            s_drive <= 1'b0;
        end else if (!s_pscl && scl) begin
            if (s_bits < 8) s_rx <= {s_rx[6:0], sda};
            s_bits <= s_bits + 1;
        end else if (s_pscl && !scl) begin
            if (s_bits == 8) s_drive <= ack_en;
            else if (s_bits == 9) begin
                s_drive <= 1'b0;
                s_bits  <= 0;
                rxq.push_back(s_rx);
            end
        end
    end

    // Waveform timing monitor.
    int   ncyc = 0, rise_t = 0, t_start = 0, t_rise = -100000, txd_n = 0;
    int   hi_n = 0, hi_min = 1 << 30, hi_max = 0;
    logic want_rise = 1'b0, meas_hi = 1'b0, mon_pscl = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_pscl && scl) begin
                rise_t = ncyc;
                if (want_rise) begin t_rise = ncyc; want_rise = 1'b0; end
            end
            if (mon_pscl && !scl && meas_hi) begin
                hi_n++;
                if (ncyc - rise_t < hi_min) hi_min = ncyc - rise_t;
                if (ncyc - rise_t > hi_max) hi_max = ncyc - rise_t;
            end
            if (bus_if.tx_done) txd_n++;
            mon_pscl = scl;
            ncyc++;
        end
    end

    // Caller is at a negedge; command is seen by the next posedge.
    task automatic pulse(input int which);
        if (which == 0) bus_if.cmd_start = 1'b1;
        if (which == 1) bus_if.cmd_write = 1'b1;
        if (which == 2) bus_if.cmd_stop  = 1'b1;
        @(negedge clk);
        bus_if.cmd_start = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_stop  = 1'b0;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 2000 && !bus_if.ready; i++) @(negedge clk);
        if (!bus_if.ready) chk("wait ready timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output logic ae);
        int i;
        ae = 1'bx;
        for (i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (bus_if.tx_done) break;
        end
        if (bus_if.tx_done) ae = bus_if.ack_err;
        else chk("wait tx_done timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus_if.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic ae;
        int   n, n0;
        bus_if.cmd_start = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_stop  = 1'b0;
        bus_if.tx_data   = 8'h00;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset scl", scl, 1'b1);
        chk("reset sda", sda, 1'b1);
        chk("reset ready", bus_if.ready, 1'b1);
        chk("reset busy", bus_if.busy, 1'b0);
        chk("reset tx_done", bus_if.tx_done, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Reset asserted during bit 4 of a byte.
        pulse(0);
        wait_ready();
        bus_if.tx_data = 8'hE0;
        pulse(1);
        repeat (3*4*Div + 2*Div) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midbyte reset scl", scl, 1'b1);
        chk("midbyte reset sda", sda, 1'b1);
        chk("midbyte reset ready", bus_if.ready, 1'b1);
        chk("midbyte reset busy", bus_if.busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        n0 = txd_n;
        repeat (9100) @(negedge clk);
        chk("no tx_done after reset", txd_n - n0, 0);

        // Write in IDLE is ignored.
        bus_if.tx_data = 8'hAA;
        pulse(1);
        repeat (10) @(negedge clk);
        chk("idle write busy", bus_if.busy, 1'b0);
        chk("idle write scl", scl, 1'b1);

        // Two acknowledged bytes, a stray START mid-byte, then STOP.
        ack_en = 1'b1;
        pulse(0);
        t_start = ncyc;
        want_rise = 1'b1;
        wait_ready();
        meas_hi = 1'b1;
        bus_if.tx_data = 8'hE0;
        pulse(1);
        repeat (6*Div) @(negedge clk);
        pulse(0);
        wait_done(ae);
        chk("byte1 ack_err", ae, 1'b0);
        bus_if.tx_data = 8'h5A;
        pulse(1);
        wait_done(ae);
        chk("byte2 ack_err", ae, 1'b0);
        meas_hi = 1'b0;
        pulse(2);
        wait_idle(n);
        chk("stop to busy low", n, 1000);
        chk_rng("start to first scl rise", t_rise - t_start, 1248, 1252);
        chk("scl high count", hi_n, 18);
        chk("scl high min", hi_min, 500);
        chk("scl high max", hi_max, 500);

        // No slave: NACK is reported and the engine parks in HOLD.
        pulse(0);
        wait_ready();
        ack_en = 1'b0;
        bus_if.tx_data = 8'hE0;
        pulse(1);
        wait_done(ae);
        chk("nack ack_err", ae, 1'b1);
        chk("nack ready", bus_if.ready, 1'b1);
        chk("nack busy", bus_if.busy, 1'b1);

        // Write and stop together: the byte goes out, no STOP.
        ack_en = 1'b1;
        bus_if.tx_data = 8'hFF;
        bus_if.cmd_stop = 1'b1;
        pulse(1);
        wait_done(ae);
        chk("ff ack_err", ae, 1'b0);
        repeat (20) @(negedge clk);
        chk("ff no stop busy", bus_if.busy, 1'b1);
        chk("ff ready", bus_if.ready, 1'b1);
        chk("ff scl held low", scl, 1'b0);
        pulse(2);
        wait_idle(n);
        chk("final stop", n, 1000);

        chk("rx count", rxq.size(), 4);
        if (rxq.size() == 4) begin
            chk("rx0", rxq[0], 8'hE0);
            chk("rx1", rxq[1], 8'h5A);
            chk("rx2", rxq[2], 8'hE0);
            chk("rx3", rxq[3], 8'hFF);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
